// File: rtl/keysched_pkg.sv
// Shared types and constants for the AES-128 round-key sequencer.
package keysched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic        DIR_ENC    = 1'b0;
  localparam logic        DIR_DEC    = 1'b1;
  localparam int unsigned NR_DEFAULT = 10;

endpackage

// File: rtl/keysched_rr_arb.sv
// Two-way round-robin arbiter: bit 0 = encrypt, bit 1 = decrypt.
// Priority flips to the loser only when both requests contend.
module keysched_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_prio;

  always_comb begin
    grant = '0;
    if (&req) grant = r_prio ? 2'b10 : 2'b01;
    else      grant = req;
  end

  always_ff @(posedge clock) begin
    if (reset)                r_prio <= 1'b0;
    else if (advance && &req) r_prio <= ~r_prio;
  end

endmodule

// File: rtl/key_round_sched.sv
// AES-128 round-key sequencer: arbitrates encrypt/decrypt jobs and walks keymem.
// Optional consumer back-pressure via rk_ready when KEYSCHED_READY_EN is defined.
module key_round_sched
  import keysched_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT,
  parameter int unsigned AW = 4,
  parameter int unsigned KW = 128
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enc_req,
  input  logic          dec_req,
  output logic          enc_gnt,
  output logic          dec_gnt,
  output logic [AW-1:0] mem_add,
  output logic          mem_en,
  input  logic [KW-1:0] mem_dout,
  output logic [KW-1:0] rk,
  output logic          rk_valid,
  output logic [AW-1:0] rk_round,
  output logic          rk_dir,
  output logic          rk_last,
  output logic          busy
`ifdef KEYSCHED_READY_EN
  ,
  input  logic          rk_ready
`endif
);

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_round;
  logic          r_dir;
  logic          r_enc_gnt;
  logic          r_dec_gnt;
  logic          r_rk_valid;
  logic [AW-1:0] r_rk_round;
  logic          r_rk_dir;
  logic          r_rk_last;

  logic [1:0]    w_grant;
  logic          w_start;
  logic          w_stall;
  logic          w_issue;
  logic          w_last;

`ifdef KEYSCHED_READY_EN
  assign w_stall = r_rk_valid && !rk_ready;
`else
  assign w_stall = 1'b0;
`endif

  assign w_start = (r_state == IDLE) && (enc_req || dec_req);
  assign w_issue = (r_state == ISSUE) && !w_stall;
  assign w_last  = (r_round == AW'(NR));

  keysched_rr_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({dec_req, enc_req}),
    .advance (w_start),
    .grant   (w_grant)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_round    <= '0;
      r_dir      <= DIR_ENC;
      r_enc_gnt  <= 1'b0;
      r_dec_gnt  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_rk_round <= '0;
      r_rk_dir   <= 1'b0;
      r_rk_last  <= 1'b0;
    end else begin
      r_enc_gnt <= w_start && w_grant[0];
      r_dec_gnt <= w_start && w_grant[1];

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= ISSUE;
            r_dir   <= w_grant[1] ? DIR_DEC : DIR_ENC;
            r_addr  <= w_grant[1] ? AW'(NR) : '0;
            r_round <= '0;
          end
        end
        ISSUE: begin
          // Counter stops on the last round, so the address never leaves 0..NR.
          if (w_issue) begin
            if (w_last) begin
              r_state <= DRAIN;
            end else begin
              r_round <= r_round + 1'b1;
              r_addr  <= (r_dir == DIR_DEC) ? r_addr - 1'b1 : r_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!w_stall) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Tags follow the read by one cycle and freeze with the key under stall.
      if (!w_stall) begin
        r_rk_valid <= w_issue;
        r_rk_round <= w_issue ? r_round : '0;
        r_rk_dir   <= w_issue ? r_dir : 1'b0;
        r_rk_last  <= w_issue && w_last;
      end
    end
  end

  assign enc_gnt  = r_enc_gnt;
  assign dec_gnt  = r_dec_gnt;
  assign mem_add  = r_addr;
  assign mem_en   = w_issue;
  assign rk       = mem_dout;
  assign rk_valid = r_rk_valid;
  assign rk_round = r_rk_round;
  assign rk_dir   = r_rk_dir;
  assign rk_last  = r_rk_last;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_key_round_sched.sv
// Directed bench for key_round_sched with a keymem model holding key i = {16{i[7:0]}}.
module tb_key_round_sched;

  localparam int NR = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enc_req = 1'b0;
  logic         dec_req = 1'b0;
  logic         enc_gnt, dec_gnt;
  logic [3:0]   mem_add;
  logic         mem_en;
  logic [127:0] mem_dout = '0;
  logic [127:0] rk;
  logic         rk_valid;
  logic [3:0]   rk_round;
  logic         rk_dir, rk_last, busy;
`ifdef KEYSCHED_READY_EN
  logic         rk_ready = 1'b1;
`endif

  int checks = 0;
  int failures = 0;

  key_round_sched #(.NR(10), .AW(4), .KW(128)) dut (
    .clock    (clock),
    .reset    (reset),
    .enc_req  (enc_req),
    .dec_req  (dec_req),
    .enc_gnt  (enc_gnt),
    .dec_gnt  (dec_gnt),
    .mem_add  (mem_add),
    .mem_en   (mem_en),
    .mem_dout (mem_dout),
    .rk       (rk),
    .rk_valid (rk_valid),
    .rk_round (rk_round),
    .rk_dir   (rk_dir),
    .rk_last  (rk_last),
    .busy     (busy)
`ifdef KEYSCHED_READY_EN
    ,
    .rk_ready (rk_ready)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] key(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {16{b}};
  endfunction

  // Registered-read keymem: dout updates only when en is high.
  always @(posedge clock) if (mem_en) mem_dout <= key(int'(mem_add));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at grant cycle T; returns at T+NR+2 (first idle cycle).
  // enc_req is raised at iteration pon and dropped at poff (negative = untouched).
  task automatic check_job(input logic dir, input int pon, input int poff);
    for (int i = 0; i <= NR; i++) begin
      if (i == pon)  enc_req = 1'b1;
      if (i == poff) enc_req = 1'b0;
      chk("enc_gnt", enc_gnt, (i == 0) && !dir);
      chk("dec_gnt", dec_gnt, (i == 0) && dir);
      chk("busy", busy, 1'b1);
      chk("mem_en", mem_en, 1'b1);
      chk("mem_add", mem_add, dir ? NR - i : i);
      chk("rk_valid", rk_valid, i > 0);
      if (i > 0) begin
        chk("rk_round", rk_round, i - 1);
        chk("rk", rk, key(dir ? NR - (i - 1) : i - 1));
        chk("rk_dir", rk_dir, dir);
        chk("rk_last", rk_last, 1'b0);
      end
      tick();
    end
    chk("drain_mem_en", mem_en, 1'b0);
    chk("drain_busy", busy, 1'b1);
    chk("last_valid", rk_valid, 1'b1);
    chk("last_round", rk_round, NR);
    chk("last_rk", rk, key(dir ? 0 : NR));
    chk("last_flag", rk_last, 1'b1);
    chk("last_dir", rk_dir, dir);
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", rk_valid, 1'b0);
    chk("idle_mem_en", mem_en, 1'b0);
    chk("idle_enc_gnt", enc_gnt, 1'b0);
    chk("idle_dec_gnt", dec_gnt, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_add", mem_add, 4'd0);
    chk("rst_gnt", {enc_gnt, dec_gnt}, 2'b00);
    chk("rst_round", rk_round, 4'd0);
    chk("rst_last", rk_last, 1'b0);
    reset = 1'b0;
    tick();

    // Lone encrypt request
    enc_req = 1'b1;
    tick();
    enc_req = 1'b0;
    check_job(1'b0, -1, -1);
    tick();

    // Lone decrypt request
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    check_job(1'b1, -1, -1);
    tick();

    // Both held: enc, dec, enc with one idle cycle between jobs
    enc_req = 1'b1;
    dec_req = 1'b1;
    tick();
    check_job(1'b0, -1, -1);
    tick();
    check_job(1'b1, -1, -1);
    tick();
    check_job(1'b0, -1, -1);
    enc_req = 1'b0;
    dec_req = 1'b0;
    tick();

    // Encrypt pulse during a decrypt job is dropped
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    check_job(1'b1, 3, 4);
    tick();
    chk("pulse_ignored_gnt", enc_gnt, 1'b0);
    chk("pulse_ignored_busy", busy, 1'b0);
    tick();

    // Encrypt request still high when IDLE is reached starts a new job
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    check_job(1'b1, 5, -1);
    tick();
    enc_req = 1'b0;
    check_job(1'b0, -1, -1);

    // Mid-job reset at T+5, then restart with encrypt priority
    enc_req = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("pre_rst_add", mem_add, i);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", rk_valid, 1'b0);
    chk("abort_mem_en", mem_en, 1'b0);
    chk("abort_gnt", {enc_gnt, dec_gnt}, 2'b00);
    dec_req = 1'b1;
    tick();
    check_job(1'b0, -1, -1);
    enc_req = 1'b0;
    dec_req = 1'b0;
    tick();

`ifdef KEYSCHED_READY_EN
    // Hold off rk_ready for 3 cycles while round 4 is presented
    enc_req = 1'b1;
    tick();
    enc_req = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      rk_ready = !(c >= 5 && c <= 7);
      #1;
      chk("stall_valid", rk_valid, 1'b1);
      chk("stall_round", rk_round, (c <= 4) ? c - 1 : ((c <= 8) ? 4 : c - 4));
      chk("stall_rk", rk, key((c <= 4) ? c - 1 : ((c <= 8) ? 4 : c - 4)));
      chk("stall_last", rk_last, c == 14);
      chk("stall_mem_en", mem_en, (c <= 4) || (c >= 8 && c <= 13));
      if (c <= 13) chk("stall_mem_add", mem_add, (c <= 4) ? c : ((c <= 8) ? 5 : c - 3));
    end
    rk_ready = 1'b1;
    tick();
    chk("stall_done_busy", busy, 1'b0);
    chk("stall_done_valid", rk_valid, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
